bus_arbiter: RTL and testbench

- Shares one 8-bit tri-state data bus among `NUM_WRITERS` request/busy writers.
- Grants exactly one requester at a time by driving its `busy` low.
- Samples the bus while that writer drives it, and presents the word on a registered valid/ready output port with the source index.
- Sits between the writer instances and the downstream consumer; it is the only block that releases `busy`.

---
 rtl/bus_arbiter_if.sv | 37 +++
 rtl/bus_arbiter.sv | 126 ++++++++++++
 tb/tb_bus_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - writer bus and output port bundle for bus_arbiter
//
// Purpose: groups the shared writer bus (req/busy/data) and the registered
// valid/ready output port of bus_arbiter into one interface.
//
// Signals:
//   req       writer -> arbiter, one bit per writer, 1 = requesting
//   busy      arbiter -> writer, one bit per writer, 0 = granted (drive bus)
//   data      shared writer bus, meaningful only while a granted writer holds req
//   out_data  captured word
//   out_src   index of the writer that produced out_data (zero-extended)
//   out_valid out_data/out_src hold an unconsumed word
//   out_ready consumer accepts the word when out_valid && out_ready
//
// Modports: master = arbiter side, slave = writers/consumer side.
interface bus_arbiter_if #(
  parameter int NUM_WRITERS = 4,
  parameter int DATA_WIDTH  = 8
);
  logic [NUM_WRITERS-1:0] req;
  logic [NUM_WRITERS-1:0] busy;
  logic [DATA_WIDTH-1:0]  data;
  logic [DATA_WIDTH-1:0]  out_data;
  logic [2:0]             out_src;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    input  req, data, out_ready,
    output busy, out_data, out_src, out_valid
  );

  modport slave (
    output req, data, out_ready,
    input  busy, out_data, out_src, out_valid
  );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - grants one writer at a time on a shared bus and forwards its word
//
// Purpose: arbitrates NUM_WRITERS request/busy writers sharing one data bus.
// A winner gets busy low for exactly one cycle, its bus word is captured and
// presented on a registered valid/ready output together with its index.
//
// Ports:
//   clk    single clock, all logic on posedge
//   reset  synchronous, active-high
//   bus    bus_arbiter_if.master: req, busy, data, out_data, out_src,
//          out_valid, out_ready
//
// Configuration:
//   BUS_ARBITER_ROUND_ROBIN_EN  defined: round-robin search starting at ptr,
//                              ptr advances past each successful winner.
//                              undefined: fixed priority, lowest index wins.
module bus_arbiter #(
  parameter int NUM_WRITERS = 4,
  parameter int DATA_WIDTH  = 8
) (
  input  logic           clk,
  input  logic           reset,
  bus_arbiter_if.master  bus
);

  localparam int IW = $clog2(NUM_WRITERS);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t                  state;
  logic [IW-1:0]           gnt;
  logic [IW-1:0]           win;
  logic [NUM_WRITERS-1:0]  busy_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic [2:0]              out_src_q;
  logic                    out_valid_q;
  logic                    slot_free;

  // A new grant is only allowed when its capture cannot overwrite a word the
  // consumer has not taken yet.
  assign slot_free = !out_valid_q || bus.out_ready;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  logic [IW-1:0] ptr;

  always_comb begin : pick_winner
    int   j;
    logic found;
    win   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_WRITERS; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_WRITERS) j = j - NUM_WRITERS;
      if (!found && bus.req[IW'(j)]) begin
        win   = IW'(j);
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin : pick_winner
    win = '0;
    // Scanning downward leaves the lowest set index as the final winner.
    for (int i = NUM_WRITERS - 1; i >= 0; i--) begin
      if (bus.req[IW'(i)]) win = IW'(i);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= '0;
      busy_q      <= '1;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      ptr         <= '0;
`endif
    end else begin
      // Consumption first; a capture below in the same cycle overrides it.
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;

      case (state)
        IDLE: begin
          busy_q <= '1;
          if ((bus.req != '0) && slot_free) begin
            busy_q <= ~(NUM_WRITERS'(1) << win);
            gnt    <= win;
            state  <= GRANT;
          end
        end

        GRANT: begin
          // Writer still requesting means it drove the bus this cycle.
          if (bus.req[gnt]) begin
            out_data_q  <= bus.data;
            out_src_q   <= 3'(gnt);
            out_valid_q <= 1'b1;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
            ptr <= (gnt == IW'(NUM_WRITERS - 1)) ? '0 : gnt + IW'(1);
`endif
          end
          busy_q <= '1;
          state  <= IDLE;
        end

        default: begin
          busy_q <= '1;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard testbench for bus_arbiter
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bus_arbiter_if #(.NUM_WRITERS(N), .DATA_WIDTH(DW)) bus ();

  bus_arbiter #(.NUM_WRITERS(N), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [2:0]    s;
  } word_t;

  int     checks   = 0;
  int     failures = 0;
  word_t  exp_q[$];
  int     grant_log[$];

  // Reference model state: pending grant index (-1 none), output slot
  // occupancy and round-robin start point.
  int     m_gnt   = -1;
  bit     m_valid = 1'b0;
  int     m_ptr   = 0;

  bit     sent[N];
  bit     raise_en = 1'b0;
  bit     abort_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r);
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    for (int k = 0; k < N; k++) begin
      if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
`else
    for (int k = 0; k < N; k++) begin
      if (r[k]) return k;
    end
`endif
    return -1;
  endfunction

  // One clock: remember what the DUT sees at the edge, advance the model,
  // then compare the post-edge outputs.
  task automatic step();
    logic [N-1:0]  pv_req;
    logic [DW-1:0] pv_data;
    logic          pv_ready;
    logic          pv_reset;
    logic [N-1:0]  exp_busy;
    bit            hs;
    word_t         w;
    pv_req   = bus.req;
    pv_data  = bus.data;
    pv_ready = bus.out_ready;
    pv_reset = reset;
    @(posedge clk);
    #1;
    exp_busy = '1;
    if (pv_reset) begin
      m_valid = 1'b0;
      m_gnt   = -1;
      m_ptr   = 0;
      exp_q.delete();
      chk("reset_out_data", 32'(bus.out_data), 32'h0);
      chk("reset_out_src", 32'(bus.out_src), 32'h0);
    end else begin
      hs = m_valid && pv_ready;
      if (m_gnt >= 0) begin
        if (pv_req[m_gnt]) begin
          w.d = pv_data;
          w.s = 3'(m_gnt);
          exp_q.push_back(w);
          m_valid = 1'b1;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
          m_ptr = (m_gnt + 1) % N;
`endif
        end else if (hs) begin
          m_valid = 1'b0;
        end
        m_gnt = -1;
      end else if (pv_req != '0 && (!m_valid || pv_ready)) begin
        m_gnt    = pick(pv_req);
        exp_busy = ~(N'(1) << m_gnt);
        if (hs) m_valid = 1'b0;
      end else begin
        if (hs) m_valid = 1'b0;
      end
    end
    chk("busy", 32'(bus.busy), 32'(exp_busy));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("single_driver", 32'($countones(~bus.busy) <= 1), 32'h1);
    for (int i = 0; i < N; i++) begin
      if (bus.busy[i] === 1'b0) grant_log.push_back(i);
    end
  endtask

  // Writers react to the DUT's busy like real bus writers.
  task automatic writer_policy();
    bit granted;
    granted = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bus.busy[i] === 1'b0) begin
        if (abort_en && $urandom_range(0, 5) == 0) begin
          bus.req[i] = 1'b0;
        end else begin
          sent[i]  = 1'b1;
          granted  = 1'b1;
          bus.data = DW'($urandom);
        end
      end else if (sent[i]) begin
        bus.req[i] = 1'b0;
        sent[i]    = 1'b0;
      end else if (!bus.req[i] && raise_en && $urandom_range(0, 3) == 0) begin
        bus.req[i] = 1'b1;
      end
    end
    if (!granted) bus.data = DW'($urandom);
  endtask

  // Monitor: every accepted word must match the oldest expected word.
  always @(negedge clk) begin
    word_t e;
    if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_word: unexpected word data=0x%0h src=%0d, expected none", bus.out_data, bus.out_src);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(e.d));
        chk("out_src", 32'(bus.out_src), 32'(e.s));
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) sent[i] = 1'b0;
    reset         = 1'b1;
    bus.req       = '0;
    bus.data      = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Idle: nothing requested, everything stays blocked.
    repeat (10) step();
    chk("idle_busy", 32'(bus.busy), 32'hF);
    chk("idle_out_valid", 32'(bus.out_valid), 32'h0);

    // Single writer 2 with 0x0A.
    bus.out_ready = 1'b1;
    bus.req       = 4'b0100;
    bus.data      = 8'h0A;
    step();
    chk("single_busy_low", 32'(bus.busy), 32'hB);
    step();
    chk("single_busy_high", 32'(bus.busy), 32'hF);
    chk("single_valid", 32'(bus.out_valid), 32'h1);
    chk("single_data", 32'(bus.out_data), 32'h0A);
    chk("single_src", 32'(bus.out_src), 32'h2);
    bus.req = '0;
    step();
    step();

    // Contention among writers 0, 1, 3.
    grant_log.delete();
    bus.req  = 4'b1011;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    repeat (8) begin
      step();
      writer_policy();
    end
    chk("contention_count", 32'(grant_log.size()), 32'd3);
    if (grant_log.size() == 3) begin
      chk("contention_first", 32'(grant_log[0]), 32'd0);
      chk("contention_second", 32'(grant_log[1]), 32'd1);
      chk("contention_third", 32'(grant_log[2]), 32'd3);
    end
`else
    repeat (8) begin
      step();
      bus.data = DW'($urandom);
    end
    chk("contention_count", 32'(grant_log.size()), 32'd4);
    foreach (grant_log[k]) chk("contention_winner", 32'(grant_log[k]), 32'd0);
`endif
    bus.req = '0;
    repeat (3) step();

    // Backpressure: held word blocks writer 1 until the consumer is ready.
    bus.out_ready = 1'b0;
    bus.req       = 4'b0001;
    bus.data      = 8'h55;
    step();
    step();
    bus.req  = 4'b0010;
    bus.data = 8'h66;
    repeat (5) step();
    chk("bp_busy", 32'(bus.busy), 32'hF);
    chk("bp_valid", 32'(bus.out_valid), 32'h1);
    chk("bp_data_hold", 32'(bus.out_data), 32'h55);
    bus.out_ready = 1'b1;
    step();
    chk("bp_release_grant", 32'(bus.busy), 32'hD);
    step();
    bus.req = '0;
    step();
    step();

    // Abort: writer 2 drops req while granted.
    bus.req  = 4'b0100;
    bus.data = 8'h77;
    step();
    chk("abort_grant", 32'(bus.busy), 32'hB);
    bus.req = '0;
    step();
    chk("abort_no_valid", 32'(bus.out_valid), 32'h0);
    step();
    chk("abort_still_no_valid", 32'(bus.out_valid), 32'h0);
    bus.req  = 4'b1100;
    bus.data = 8'h88;
    step();
    chk("abort_next_grant", 32'(bus.busy), 32'hB);
    step();
    chk("abort_next_data", 32'(bus.out_data), 32'h88);
    bus.req = '0;
    step();

    // Reset asserted while a grant is in flight.
    bus.req  = 4'b0010;
    bus.data = 8'h99;
    step();
    chk("rst_grant", 32'(bus.busy), 32'hD);
    reset = 1'b1;
    step();
    chk("rst_busy", 32'(bus.busy), 32'hF);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_data", 32'(bus.out_data), 32'h0);
    reset   = 1'b0;
    bus.req = '0;
    step();
    step();
    chk("rst_after_valid", 32'(bus.out_valid), 32'h0);

    // Random traffic with backpressure and aborts.
    raise_en = 1'b1;
    abort_en = 1'b1;
    repeat (400) begin
      step();
      writer_policy();
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    raise_en      = 1'b0;
    abort_en      = 1'b0;
    bus.out_ready = 1'b1;
    repeat (24) begin
      step();
      writer_policy();
    end
    chk("drain_req", 32'(bus.req), 32'h0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
